// File: rtl/pht_sat.sv
// Pattern history table of saturating counters, initialised by a one-entry-per-cycle sweep.
// Lookups are combinational; training is a single-cycle read-modify-write.
module pht_sat #(
    parameter int IDX_W = 8,
    parameter int CTR_W = 2,
    parameter int INIT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_index,
    output logic [CTR_W-1:0] rd_ctr,
    output logic             rd_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken,
    output logic             ready
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(INIT);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [IDX_W-1:0] PTR_LAST = {IDX_W{1'b1}};

    typedef enum logic {SWEEP, RUN} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic             ready_reg;
    logic [CTR_W-1:0] table_mem [DEPTH];

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [CTR_W-1:0] wr_data;
    logic [CTR_W-1:0] upd_cur;
    logic [CTR_W-1:0] upd_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SWEEP;
            ptr_reg   <= '0;
            ready_reg <= 1'b0;
        end else if (flush) begin
            state_reg <= SWEEP;
            ptr_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                SWEEP: begin
                    ptr_reg <= ptr_reg + 1'b1;
                    if (ptr_reg == PTR_LAST) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    state_reg <= RUN;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= SWEEP;
                    ptr_reg   <= '0;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Saturating step of the entry being trained
    always_comb begin
        upd_cur  = table_mem[upd_index];
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CTR_MAX) upd_next = upd_cur + 1'b1;
        end else begin
            if (upd_cur != '0) upd_next = upd_cur - 1'b1;
        end
    end

    // One write port shared by the sweep and training; rst and flush block both.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ptr_reg;
        wr_data = INIT_VAL;
        if (!rst && !flush) begin
            if (state_reg == SWEEP) begin
                wr_en   = 1'b1;
                wr_addr = ptr_reg;
                wr_data = INIT_VAL;
            end else if (upd_valid) begin
                wr_en   = 1'b1;
                wr_addr = upd_index;
                wr_data = upd_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) table_mem[wr_addr] <= wr_data;
    end

    assign rd_ctr   = (state_reg == RUN) ? table_mem[rd_index] : INIT_VAL;
    assign rd_taken = rd_ctr[CTR_W-1];
    assign ready    = ready_reg;

endmodule

// File: tb/tb_pht_sat.sv
// Bench for pht_sat: default instance checked against a behavioural table model,
// plus a small instance (IDX_W=4, CTR_W=3, INIT=4) checked with directed values.
module tb_pht_sat;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] rd_index = '0;
    logic [1:0] rd_ctr;
    logic       rd_taken;
    logic       upd_valid = 1'b0;
    logic [7:0] upd_index = '0;
    logic       upd_taken = 1'b0;
    logic       ready;

    logic       b_flush = 1'b0;
    logic [3:0] b_rd_index = '0;
    logic [2:0] b_rd_ctr;
    logic       b_rd_taken;
    logic       b_upd_valid = 1'b0;
    logic [3:0] b_upd_index = '0;
    logic       b_upd_taken = 1'b0;
    logic       b_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: entry values and remaining sweep cycles (0 means table ready)
    int m_mem [256];
    int m_rem = 256;

    always #5 clk = ~clk;

    pht_sat #(.IDX_W(8), .CTR_W(2), .INIT(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rd_index(rd_index), .rd_ctr(rd_ctr), .rd_taken(rd_taken),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .ready(ready)
    );

    pht_sat #(.IDX_W(4), .CTR_W(3), .INIT(4)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .rd_index(b_rd_index), .rd_ctr(b_rd_ctr), .rd_taken(b_rd_taken),
        .upd_valid(b_upd_valid), .upd_index(b_upd_index), .upd_taken(b_upd_taken),
        .ready(b_ready)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_rd(input int idx);
        return (m_rem == 0) ? m_mem[idx] : 1;
    endfunction

    task automatic model_init();
        m_rem = 256;
        foreach (m_mem[i]) m_mem[i] = 1;
    endtask

    // Advance one clock edge and apply the sampled inputs to the model
    task automatic tick();
        logic r, f, v, t;
        int   ui;
        r = rst; f = flush; v = upd_valid; t = upd_taken; ui = int'(upd_index);
        @(posedge clk);
        if (r || f) model_init();
        else if (m_rem > 0) m_rem--;
        else if (v) begin
            if (t) m_mem[ui] = (m_mem[ui] >= 3) ? 3 : m_mem[ui] + 1;
            else   m_mem[ui] = (m_mem[ui] <= 0) ? 0 : m_mem[ui] - 1;
        end
        #1;
    endtask

    task automatic check_state(input string tag);
        int e;
        #1;
        e = exp_rd(int'(rd_index));
        chk({tag, "_ready"}, int'(ready), (m_rem == 0) ? 1 : 0);
        chk({tag, "_rd_ctr"}, int'(rd_ctr), e);
        chk({tag, "_rd_taken"}, int'(rd_taken), (e >= 2) ? 1 : 0);
    endtask

    task automatic wait_ready(input string tag, input int expected_len);
        int n;
        n = 0;
        while (!ready && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_sweep_len"}, n, expected_len);
    endtask

    task automatic check_all_init(input string tag);
        for (int i = 0; i < 256; i++) begin
            rd_index = 8'(i);
            #1;
            chk(tag, int'(rd_ctr), 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_2a [7];
        int seq_b  [12];
        seq_2a = '{2, 3, 3, 2, 1, 0, 0};
        seq_b  = '{5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0};
        model_init();

        // Reset: INIT visible, updates ignored
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_index  = 8'($urandom_range(0, 255));
            upd_index = rd_index;
            check_state("reset");
            chk("reset_b_rd_ctr", int'(b_rd_ctr), 4);
            chk("reset_b_rd_taken", int'(b_rd_taken), 1);
            tick();
        end
        rst = 1'b0;

        // Initial sweep with random (ignored) updates
        for (int cyc = 1; cyc <= 256; cyc++) begin
            upd_valid = 1'($urandom_range(0, 1));
            upd_taken = 1'($urandom_range(0, 1));
            upd_index = 8'($urandom_range(0, 255));
            rd_index  = 8'($urandom_range(0, 255));
            check_state("sweep");
            tick();
            chk("b_ready_sweep", int'(b_ready), (cyc >= 16) ? 1 : 0);
        end
        upd_valid = 1'b0;
        check_state("after_sweep");
        chk("ready_after_256", int'(ready), 1);
        check_all_init("init_entry");

        // Saturation at index 0x2A
        rd_index  = 8'h2A;
        upd_index = 8'h2A;
        upd_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            upd_taken = (i < 3);
            tick();
            #1;
            chk("sat_2a", int'(rd_ctr), seq_2a[i]);
        end
        upd_valid = 1'b0;

        // Same-index read and update: old value now, new value next cycle
        rd_index  = 8'h10;
        upd_index = 8'h10;
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        #1;
        chk("bypass_before", int'(rd_ctr), 1);
        tick();
        upd_valid = 1'b0;
        #1;
        chk("bypass_after", int'(rd_ctr), 2);
        chk("bypass_taken", int'(rd_taken), 1);

        // Random training against the model, small index set to force collisions
        for (int i = 0; i < 400; i++) begin
            upd_valid = 1'($urandom_range(0, 3) != 0);
            upd_taken = 1'($urandom_range(0, 1));
            upd_index = 8'($urandom_range(0, 7));
            rd_index  = ($urandom_range(0, 3) == 0) ? upd_index : 8'($urandom_range(0, 7));
            check_state("rand");
            tick();
        end
        upd_valid = 1'b0;

        // Train 0x05 to 3, then flush alongside an update to 0x05
        upd_index = 8'h05;
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        repeat (3) tick();
        rd_index = 8'h05;
        #1;
        chk("train_05", int'(rd_ctr), 3);
        flush     = 1'b1;
        upd_taken = 1'b0;
        tick();
        flush     = 1'b0;
        upd_valid = 1'b0;
        check_state("flush");
        chk("flush_ready_drop", int'(ready), 0);
        wait_ready("flush", 256);
        rd_index = 8'h05;
        check_state("flush_done");
        chk("flush_05", int'(rd_ctr), 1);

        // Flush held several cycles keeps the sweep parked
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("flush_held_ready", int'(ready), 0);
        end
        flush = 1'b0;
        wait_ready("flush_held", 256);

        // Train entries outside the part of the sweep that will complete
        upd_valid = 1'b1;
        upd_taken = 1'b1;
        upd_index = 8'd200;
        repeat (2) tick();
        upd_index = 8'd0;
        upd_taken = 1'b0;
        tick();
        rd_index = 8'd200;
        check_state("pre_abort");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 100; i++) begin
            upd_index = 8'($urandom_range(0, 255));
            upd_taken = 1'($urandom_range(0, 1));
            tick();
        end

        // Asynchronous reset mid-sweep
        #2;
        rst = 1'b1;
        model_init();
        #1;
        chk("async_rst_ready", int'(ready), 0);
        chk("async_rst_rd_ctr", int'(rd_ctr), 1);
        tick();
        tick();
        rst = 1'b0;
        wait_ready("after_rst", 256);
        upd_valid = 1'b0;
        check_all_init("rst_entry");

        // Small instance: saturation at 7 and 0, prediction is MSB
        chk("b_ready", int'(b_ready), 1);
        b_rd_index  = 4'd3;
        b_upd_index = 4'd3;
        b_upd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b_upd_taken = (i < 4);
            tick();
            #1;
            chk("b_ctr", int'(b_rd_ctr), seq_b[i]);
            chk("b_taken", int'(b_rd_taken), (seq_b[i] >= 4) ? 1 : 0);
        end
        b_upd_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pht_sat.md
PHT_SAT -- requirements
Module: pht_sat

Interface
REQ-001 Parameter IDX_W, default 8, index width; table depth SHALL be 2**IDX_W entries.
REQ-002 Parameter CTR_W, default 2, saturating-counter width per entry (legal 1..4).
REQ-003 Parameter INIT, default 1, counter value written to every entry on initialisation (0 <= INIT <= 2**CTR_W-1).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous request to re-initialise the whole table.
REQ-007 rd_index  input  IDX_W  lookup index.
REQ-008 rd_ctr  output  CTR_W  counter value at rd_index.
REQ-009 rd_taken  output  1  prediction: MSB of rd_ctr.
REQ-010 upd_valid  input  1  apply a training update this cycle.
REQ-011 upd_index  input  IDX_W  entry to train.
REQ-012 upd_taken  input  1  resolved branch outcome: 1 taken, 0 not taken.
REQ-013 ready  output  1  table initialised and accepting updates.

Function
REQ-014 Block SHALL have two states: SWEEP (initialising) and RUN.
REQ-015 SWEEP: one entry per cycle, entry ptr written with INIT, ptr incremented from 0 to 2**IDX_W-1.
REQ-016 SWEEP -> RUN on the edge that writes entry 2**IDX_W-1; ready SHALL be 1 from the following cycle.
REQ-017 Sweep SHALL take exactly 2**IDX_W cycles after rst deasserts (256 for defaults).
REQ-018 ready SHALL be 0 in SWEEP and 1 in RUN.
REQ-019 flush=1 in any state SHALL force SWEEP with ptr=0 on the next edge; ready SHALL drop the cycle after flush is sampled.
REQ-020 flush held high SHALL keep ptr at 0 and state at SWEEP; sweep restarts when flush falls.
REQ-021 rd_ctr SHALL be combinational from rd_index: stored value in RUN, constant INIT in SWEEP.
REQ-022 rd_ctr SHALL reflect pre-update contents; an update to the same index is visible on the cycle after the write edge.
REQ-023 In RUN, upd_valid=1 SHALL read-modify-write entry upd_index in one cycle: upd_taken=1 increments, upd_taken=0 decrements.
REQ-024 Increment SHALL saturate at 2**CTR_W-1; decrement SHALL saturate at 0; no wrap-around.
REQ-025 Back-to-back updates to the same index on consecutive cycles SHALL each see the previously written value (no lost update).
REQ-026 upd_valid in SWEEP SHALL be ignored and SHALL leave no effect after RUN is entered.
REQ-027 upd_valid and flush in the same RUN cycle: flush wins, update discarded.
REQ-028 rd_index and upd_index SHALL be independent; any simultaneous combination SHALL be legal.
REQ-029 Storage SHALL be an array of registers without per-entry reset; initial content SHALL come only from the sweep.

Reset
REQ-030 rst=1 SHALL immediately force state SWEEP, ptr=0, ready=0, independent of clk.
REQ-031 While rst=1, rd_ctr SHALL equal INIT, rd_taken SHALL equal INIT MSB, and no entry SHALL be written.
REQ-032 rst asserted mid-sweep or mid-RUN SHALL abort all activity; the full sweep SHALL restart from entry 0 after release.

Verification
REQ-033 Defaults; release rst, count cycles -> ready=0 for 256 cycles, 1 on cycle 256; rd_ctr=1 at every index.
REQ-034 RUN, index 0x2A: 3x upd_taken=1 -> rd_ctr 2,3,3 (saturates); 4x upd_taken=0 -> 2,1,0,0.
REQ-035 RUN, upd_valid with upd_index=rd_index=0x10, upd_taken=1 -> rd_ctr=1 that cycle, 2 next cycle, rd_taken=1.
REQ-036 Train 0x05 to 3, pulse flush one cycle together with an update to 0x05 -> ready low 256 cycles, update lost, then rd_ctr[0x05]=1.
REQ-037 Assert rst asynchronously at sweep ptr=100 with updates pending -> ready=0 at once, sweep restarts at 0, ready after 256 cycles, all entries=1.
REQ-038 IDX_W=4, CTR_W=3, INIT=4 -> sweep 16 cycles; counter saturates at 7 and 0; rd_taken=1 for values 4..7.
